// File: rtl/other_mod_unit.sv
// Fixed-latency transform pipeline: out = (~in) ^ K, delivered a cycles after acceptance,
// with valid tracking and a saturating count of delivered words.
module other_mod_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned a     = 3,
  parameter int unsigned b     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [15:0]      out_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam logic [WIDTH-1:0] K_HALF = WIDTH'(WIDTH / 2);
  localparam logic [WIDTH-1:0] K      = K_HALF << b;

  if (WIDTH < 2 || a < 1 || a > 8 || b >= WIDTH) begin : g_bad_params
    $error("other_mod_unit: illegal parameters WIDTH=%0d a=%0d b=%0d", WIDTH, a, b);
  end

  logic [WIDTH-1:0] w_res;
  logic             w_tail_v;
  logic [WIDTH-1:0] w_tail_d;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic [CNT_W-1:0] r_out_cnt;

  assign w_res = (~in) ^ K;

  // The output register is the last stage; earlier stages exist only when a > 1.
  if (a == 1) begin : g_lat1
    assign w_tail_v = in_valid;
    assign w_tail_d = w_res;
  end else begin : g_pipe
    logic [a-2:0]     r_v;
    logic [WIDTH-1:0] r_d [a-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= '0;
        for (int i = 0; i < int'(a) - 1; i++) r_d[i] <= '0;
      end else begin
        r_v[0] <= in_valid;
        r_d[0] <= w_res;
        for (int i = 1; i < int'(a) - 1; i++) begin
          r_v[i] <= r_v[i-1];
          r_d[i] <= r_d[i-1];
        end
      end
    end

    assign w_tail_v = r_v[a-2];
    assign w_tail_d = r_d[a-2];
  end

  // out only loads on a valid word so it holds through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_cnt   <= '0;
    end else begin
      r_out_valid <= w_tail_v;
      if (w_tail_v) r_out <= w_tail_d;
      if (r_out_valid && (r_out_cnt != {CNT_W{1'b1}})) r_out_cnt <= r_out_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_other_mod_unit.sv
// Directed bench for other_mod_unit: default instance (a=3, K=0x40) and a=1,b=0 instance (K=16).
module tb_other_mod_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in;
  logic        out_valid, out_valid1;
  logic [31:0] out, out1;
  logic [15:0] out_cnt, out_cnt1;

  int checks = 0;
  int errors = 0;

  other_mod_unit #(.WIDTH(32), .a(3), .b(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
    .out_valid(out_valid), .out(out), .out_cnt(out_cnt)
  );

  other_mod_unit #(.WIDTH(32), .a(1), .b(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
    .out_valid(out_valid1), .out(out1), .out_cnt(out_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic        pv [5];
  logic [31:0] pd [5];
  logic [31:0] ed [5];

  initial begin
    // Reset held with in_valid high
    rst_n = 1'b0; in_valid = 1'b1; in = 32'h1234_5678;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out", out, 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_cnt", 32'(out_cnt), 32'h0);
      chk("rst_valid1", 32'(out_valid1), 32'h0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Latency: single word 0
    in = 32'h0; in_valid = 1'b1;
    tick();
    chk("lat1_valid", 32'(out_valid1), 32'h1);
    chk("lat1_out", out1, 32'hFFFF_FFEF);
    chk("lat_valid_e1", 32'(out_valid), 32'h0);
    in_valid = 1'b0; in = 32'hDEAD_BEEF;
    tick();
    chk("lat_valid_e2", 32'(out_valid), 32'h0);
    chk("lat1_valid_off", 32'(out_valid1), 32'h0);
    chk("lat1_cnt", 32'(out_cnt1), 32'h1);
    tick();
    chk("lat_valid_e3", 32'(out_valid), 32'h1);
    chk("lat_out", out, 32'hFFFF_FFBF);
    chk("lat_cnt_pre", 32'(out_cnt), 32'h0);
    tick();
    chk("lat_valid_e4", 32'(out_valid), 32'h0);
    chk("lat_out_hold", out, 32'hFFFF_FFBF);
    chk("lat_cnt", 32'(out_cnt), 32'h1);

    // Data values
    in = 32'hFFFF_FFFF; in_valid = 1'b1;
    tick();
    in = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    tick();
    chk("data_ff_valid", 32'(out_valid), 32'h1);
    chk("data_ff", out, 32'h0000_0040);
    tick();
    chk("data_1234_valid", 32'(out_valid), 32'h1);
    chk("data_1234", out, 32'hEDCB_A9C7);
    tick();
    chk("data_idle_valid", 32'(out_valid), 32'h0);
    chk("data_cnt", 32'(out_cnt), 32'h3);

    // Streaming with a bubble: 1,1,0,1 then idle
    pv[0] = 1'b1; pd[0] = 32'hA5A5_A5A5; ed[0] = 32'h5A5A_5A1A;
    pv[1] = 1'b1; pd[1] = 32'h0F0F_0F0F; ed[1] = 32'hF0F0_F0B0;
    pv[2] = 1'b0; pd[2] = 32'hDEAD_BEEF; ed[2] = 32'hF0F0_F0B0;
    pv[3] = 1'b1; pd[3] = 32'h00FF_00FF; ed[3] = 32'hFF00_FF40;
    pv[4] = 1'b0; pd[4] = 32'h1357_9BDF; ed[4] = 32'hFF00_FF40;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i < 5) ? pv[i] : 1'b0;
      in       = (i < 5) ? pd[i] : 32'h0;
      tick();
      if (i >= 2) begin
        chk($sformatf("bub_valid_%0d", i), 32'(out_valid), 32'(pv[i-2]));
        chk($sformatf("bub_out_%0d", i), out, ed[i-2]);
      end else begin
        chk($sformatf("bub_pre_valid_%0d", i), 32'(out_valid), 32'h0);
        chk($sformatf("bub_pre_out_%0d", i), out, 32'hEDCB_A9C7);
      end
    end
    chk("bub_cnt", 32'(out_cnt), 32'h6);

    // Mid-flight asynchronous reset with two words in the pipe
    in_valid = 1'b1; in = 32'h1111_1111;
    tick();
    in = 32'h2222_2222;
    tick();
    in_valid = 1'b0; in = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out", out, 32'h0);
    chk("mid_valid", 32'(out_valid), 32'h0);
    chk("mid_cnt", 32'(out_cnt), 32'h0);
    chk("mid_out1", out1, 32'h0);
    chk("mid_cnt1", 32'(out_cnt1), 32'h0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_valid_%0d", i), 32'(out_valid), 32'h0);
      chk($sformatf("post_out_%0d", i), out, 32'h0);
    end

    // Saturation of out_cnt
    in_valid = 1'b1; in = 32'h0;
    repeat (100) tick();
    chk("sat_mid_cnt", 32'(out_cnt), 32'd97);
    chk("sat_mid_cnt1", 32'(out_cnt1), 32'd99);
    repeat (65440) tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("sat_cnt", 32'(out_cnt), 32'h0000_FFFF);
    chk("sat_cnt1", 32'(out_cnt1), 32'h0000_FFFF);
    chk("sat_valid", 32'(out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
